// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-side memory responder.
// Holds the MMIO map, the STATUS register bit layout and the serial
// transmitter state encoding.
package dmem_pkg;

    // MMIO register addresses (doubleword aligned)
    localparam logic [63:0] ADDR_TXDATA = 64'h0000_0000_1000_0000;
    localparam logic [63:0] ADDR_STATUS = 64'h0000_0000_1000_0008;
    localparam logic [63:0] ADDR_CYCLE  = 64'h0000_0000_1000_0010;

    // STATUS register bit positions; FIFO count occupies [15:8]
    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // Serial transmitter states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   push, din    - enqueue din; ignored when full unless a pop happens
//                  in the same cycle
//   pop, dout    - dequeue; dout always shows the current head entry
//   full, empty  - occupancy flags
//   count        - number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full  = (count == FULL_COUNT);
        empty = (count == '0);
        dout  = mem[rd_ptr];
        rd_en = pop && !empty;
        // A pop frees a slot this cycle, so a push while full still lands
        wr_en = push && (!full || rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory for the single-cycle RISC-V core.
// Serves loads combinationally and stores on the rising edge from a
// doubleword RAM plus an MMIO window (console TX FIFO, STATUS, CYCLE).
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite - load / store strobes from the core
//   Address           - byte address, bits [2:0] ignored
//   Write_data        - store data
//   Read_data         - load data, combinational, 0 when MemRead=0
//   tx                - 8N1 serial output, idles high, registered
//   tx_busy           - transmitter is not idle, registered
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] Write_data,
    output logic [63:0] Read_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int TW    = $clog2(BAUD_DIV);
    localparam logic [63:0]   RAM_BYTES  = 64'(RAM_WORDS) << 3;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BAUD_DIV - 1);

    logic [63:0] ram [RAM_WORDS];
    logic [63:0] cycle_count;
    logic        ovf;

    logic [63:0]      addr_w;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_hit;
    logic             is_txdata;
    logic             is_status;
    logic             is_cycle;
    logic [63:0]      status_word;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [7:0]                  fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    tx_state_t      state;
    logic [TW-1:0]  bit_timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           timer_last;

    // Address decode and load mux
    always_comb begin
        addr_w    = Address & ~64'h7;
        ram_hit   = (addr_w < RAM_BYTES);
        ram_idx   = addr_w[IDX_W+2:3];
        is_txdata = (addr_w == ADDR_TXDATA);
        is_status = (addr_w == ADDR_STATUS);
        is_cycle  = (addr_w == ADDR_CYCLE);

        status_word = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = tx_busy;
        status_word[STAT_OVF]   = ovf;
        status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);

        Read_data = '0;
        if (MemRead) begin
            if (ram_hit) begin
                Read_data = ram[ram_idx];
            end else if (is_status) begin
                Read_data = status_word;
            end else if (is_cycle) begin
                Read_data = cycle_count;
            end
        end
    end

    // The shifter pops when idle or at the very end of a stop bit, which
    // is what makes back-to-back frames gapless.
    always_comb begin
        timer_last = (bit_timer == TIMER_LAST);
        fifo_push  = MemWrite && is_txdata;
        fifo_pop   = !fifo_empty &&
                     ((state == TX_IDLE) || (state == TX_STOP && timer_last));
    end

    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            ram[ram_idx] <= Write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
        end
    end

    // Overflow set takes priority over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
        end else if (MemWrite && is_status) begin
            ovf <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (Write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TX_IDLE;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        shift     <= fifo_dout;
                        bit_timer <= '0;
                        state     <= TX_START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                TX_START: begin
                    if (timer_last) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        state     <= TX_DATA;
                        tx        <= shift[0];
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                TX_DATA: begin
                    if (timer_last) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                TX_STOP: begin
                    if (timer_last) begin
                        bit_timer <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_dout;
                            state <= TX_START;
                            tx    <= 1'b0;
                        end else begin
                            state   <= TX_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed-vector bench for data_mem_responder.
// Inputs change 1 time unit after a rising edge; combinational loads and
// registered outputs are sampled before the next rising edge.
module tb_data_mem_responder;

    localparam int BAUD = 4;

    localparam logic [63:0] A_TXDATA = 64'h1000_0000;
    localparam logic [63:0] A_STATUS = 64'h1000_0008;
    localparam logic [63:0] A_CYCLE  = 64'h1000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [63:0] Address = '0;
    logic [63:0] Write_data = '0;
    logic [63:0] Read_data;
    logic        tx;
    logic        tx_busy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [63:0] cyc_model = '0;

    data_mem_responder #(
        .RAM_WORDS  (256),
        .FIFO_DEPTH (8),
        .BAUD_DIV   (BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    // Independent count of edges since reset for CYCLE expectations
    always @(posedge clk) begin
        if (reset) cyc_model <= '0;
        else       cyc_model <= cyc_model + 64'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        MemRead = 1'b0; MemWrite = 1'b1; Address = a; Write_data = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, output logic [63:0] d);
        MemWrite = 1'b0; MemRead = 1'b1; Address = a;
        #1;
        d = Read_data;
        tick();
        MemRead = 1'b0;
    endtask

    task automatic load_rw(input logic [63:0] a, input logic [63:0] wd,
                           output logic [63:0] d);
        MemRead = 1'b1; MemWrite = 1'b1; Address = a; Write_data = wd;
        #1;
        d = Read_data;
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Checks tx over one 8N1 frame from bit-time sample `skip` onward;
    // entry point is just after the edge at which the start bit began.
    task automatic expect_frame(input logic [7:0] b, input int unsigned skip);
        for (int unsigned k = skip; k < 10 * BAUD; k++) begin
            logic e;
            if (k < BAUD)          e = 1'b0;
            else if (k < 9 * BAUD) e = b[(k - BAUD) / BAUD];
            else                   e = 1'b1;
            check_vec($sformatf("tx_%02h_k%0d", b, k), {63'b0, tx}, {63'b0, e});
            tick();
        end
    endtask

    initial begin
        logic [63:0] rd;

        // Reset and CYCLE start values
        tick();
        tick();
        reset = 1'b0;
        check_vec("rst_tx", {63'b0, tx}, 64'd1);
        check_vec("rst_busy", {63'b0, tx_busy}, 64'd0);
        load(A_CYCLE, rd);  check_vec("cycle0", rd, 64'd0);
        load(A_CYCLE, rd);  check_vec("cycle1", rd, 64'd1);
        load(A_CYCLE, rd);  check_vec("cycle2", rd, 64'd2);
        load(A_STATUS, rd); check_vec("rst_status", rd, 64'h2);

        // RAM store/load, byte offset ignored, MemRead=0 gives 0
        store(64'h40, 64'hDEADBEEF_01234567);
        load(64'h40, rd); check_vec("ram_40", rd, 64'hDEADBEEF_01234567);
        load(64'h44, rd); check_vec("ram_44", rd, 64'hDEADBEEF_01234567);
        MemRead = 1'b0; Address = 64'h40;
        #1;
        check_vec("noread", Read_data, 64'd0);
        tick();

        // Simultaneous load and store returns the old value
        store(64'h48, 64'h1111_2222_3333_4444);
        load_rw(64'h48, 64'h5555_6666_7777_8888, rd);
        check_vec("rw_old", rd, 64'h1111_2222_3333_4444);
        load(64'h48, rd); check_vec("rw_new", rd, 64'h5555_6666_7777_8888);

        // RAM top word and first address past RAM
        store(64'h0,   64'hA0A0_A0A0_A0A0_A0A0);
        store(64'h7F8, 64'h0123_4567_89AB_CDEF);
        store(64'h800, 64'hFFFF_0000_FFFF_0000);
        load(64'h7F8, rd); check_vec("ram_top", rd, 64'h0123_4567_89AB_CDEF);
        load(64'h800, rd); check_vec("ram_past", rd, 64'd0);
        load(64'h0, rd);   check_vec("ram_nowrap", rd, 64'hA0A0_A0A0_A0A0_A0A0);

        // Unmapped address and read-only CYCLE
        store(64'h2000, 64'h0000_0000_0000_00AB);
        load(64'h2000, rd);   check_vec("unmapped", rd, 64'd0);
        load(64'h40, rd);     check_vec("unmapped_ram", rd, 64'hDEADBEEF_01234567);
        load(A_STATUS, rd);   check_vec("unmapped_fifo", rd, 64'h2);
        store(A_CYCLE, 64'd0);
        MemRead = 1'b1; Address = A_CYCLE;
        #1;
        check_vec("cycle_ro", Read_data, cyc_model);
        tick();
        MemRead = 1'b0;

        // Single frame of 0x55
        store(A_TXDATA, 64'h55);
        check_vec("tx_pre", {63'b0, tx}, 64'd1);
        tick();
        check_vec("busy_start", {63'b0, tx_busy}, 64'd1);
        expect_frame(8'h55, 0);
        check_vec("busy_end", {63'b0, tx_busy}, 64'd0);
        check_vec("tx_end", {63'b0, tx}, 64'd1);

        // Ten back-to-back bytes: first popped at once, eight queued, one dropped
        for (int unsigned i = 0; i < 10; i++) begin
            store(A_TXDATA, 64'(8'hC0 + 8'(i)));
        end
        load(A_TXDATA, rd); check_vec("txdata_rd", rd, 64'd0);
        load(A_STATUS, rd); check_vec("ovf_status", rd, 64'h80D);
        store(A_STATUS, 64'd0);
        load(A_STATUS, rd); check_vec("ovf_clear", rd, 64'h805);
        expect_frame(8'hC0, 12);
        for (int unsigned i = 1; i < 9; i++) begin
            expect_frame(8'(8'hC0 + 8'(i)), 0);
        end
        check_vec("burst_idle", {63'b0, tx_busy}, 64'd0);
        load(A_STATUS, rd); check_vec("burst_status", rd, 64'h2);

        // Reset mid-DATA discards the frame and the queued byte
        store(A_TXDATA, 64'hA5);
        store(A_TXDATA, 64'h3C);
        for (int unsigned i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_vec("midrst_tx", {63'b0, tx}, 64'd1);
        check_vec("midrst_busy", {63'b0, tx_busy}, 64'd0);
        load(A_STATUS, rd); check_vec("midrst_status", rd, 64'h2);
        load(64'h40, rd);   check_vec("midrst_ram", rd, 64'hDEADBEEF_01234567);
        for (int unsigned i = 0; i < 50; i++) begin
            check_vec($sformatf("midrst_quiet%0d", i), {63'b0, tx}, 64'd1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side responder for the single-cycle RISC-V core: answers the core's load/store port (MemRead, MemWrite, address, write data) with a doubleword RAM and a small MMIO window. The MMIO window holds a free-running cycle counter and a console transmitter, which is a byte FIFO drained by an 8N1 serial shifter. Loads return data combinationally in the same cycle, as the core requires. Stores and all peripheral state update on the rising clock edge.

## Interface
Parameters:
- RAM_WORDS, 256: number of 64-bit RAM words; must be a power of two.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, ≥2.
- BAUD_DIV, 16: clock cycles per serial bit; must be ≥2.

Ports:
- clk, input, 1: sole clock; rising edge.
- reset, input, 1: synchronous, active-high.
- MemRead, input, 1: load strobe.
- MemWrite, input, 1: store strobe.
- Address, input, 64: byte address; bits [2:0] are ignored.
- Write_data, input, 64: store data.
- Read_data, output, 64: load data; combinational.
- tx, output, 1: serial line; idles high.
- tx_busy, output, 1: shifter is not in IDLE.

## Operation
Address map (decode on Address with bits [2:0] cleared):
- RAM: Address < RAM_WORDS*8. Word index is Address[log2(RAM_WORDS)+2:3]. A store writes the full 64 bits.
- 0x1000_0000 TXDATA:
  - Store pushes Write_data[7:0] into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and OVF is set.
  - Loads return 0.
- 0x1000_0008 STATUS (read):
  - bit0 full, bit1 empty, bit2 tx_busy, bit3 OVF (sticky).
  - bits[15:8] = FIFO count.
  - All other bits 0.
  - Any store to STATUS clears OVF. If an overflow occurs in the same cycle, the set wins.
- 0x1000_0010 CYCLE: 64-bit counter, +1 every cycle, wraps modulo 2^64. Read-only; stores are ignored.
- Any other address: loads return 0, stores are ignored.

Read and write rules:
- Read_data is 0 whenever MemRead=0.
- If MemRead and MemWrite are both 1, the load returns the pre-store value.

Transmitter FSM: IDLE, START, DATA, STOP.
- IDLE: when the FIFO is non-empty, pop the head into the shift register, clear the bit timer, and go to START.
- START: tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA: tx = shift[0] for BAUD_DIV cycles per bit, 8 bits LSB-first, then go to STOP.
- STOP: tx=1 for BAUD_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- tx is registered.

FIFO:
- A simultaneous push and pop while full is accepted, and count is unchanged.
- A simultaneous push and pop while empty is not possible, because a pop requires non-empty in the previous state.

## Timing
- Reset values:
  - tx=1, tx_busy=0.
  - FSM=IDLE, FIFO empty (count=0), OVF=0.
  - CYCLE=0 (CYCLE reads 0 in the first cycle after reset deasserts).
  - Read_data follows the inputs.
- RAM contents are not cleared by reset.
- Load latency 0 cycles. Store visible to a load in the next cycle.
- A TXDATA store at edge N into an empty FIFO:
  - edge N+1 pops and enters START.
  - tx falls after edge N+1 (tx_busy=1 from N+1).
- Frame length is 10*BAUD_DIV cycles. Back-to-back frames are exactly 10*BAUD_DIV cycles apart.
- Reset during a frame: tx returns high at the next edge and the FIFO contents are discarded.

## Structure
- Package dmem_pkg holds:
  - MMIO address constants (TXDATA, STATUS, CYCLE).
  - STATUS bit positions.
  - The tx FSM state enum.
- Sub-module sync_fifo (parameter WIDTH and DEPTH; push/pop/full/empty/count) is instantiated for the TX FIFO.
- Decode, RAM, counter and FSM stay in the top module.

## Test plan
- Store 0xDEADBEEF_01234567 to 0x40, then load 0x40 and 0x44 → both return that value. Load with MemRead=0 → 0.
- Reset, then load CYCLE three consecutive cycles → 0, 1, 2.
- BAUD_DIV=4, store 0x55 to TXDATA → tx low 4 cycles starting one cycle after the store. Then 1,0,1,0,1,0,1,0 (4 cycles each), high stop. tx_busy=0 after 40 cycles.
- Store 10 bytes back-to-back with FIFO_DEPTH=8 → 9 bytes transmitted contiguously (one popped immediately), 1 dropped. STATUS bit3=1. A store to STATUS clears it.
- Assert reset mid-DATA → next cycle tx=1, STATUS=0x2 (empty), no further frames.
- Load 0x2000 and store to 0x2000 → returns 0, and RAM and FIFO are unchanged.
